// File: rtl/sd_img_pkg.sv
// Shared definitions for the SD image read/write paths: FSM states, sector and FIFO geometry.
package sd_img_pkg;

  localparam int unsigned SEC_WORDS_DEF  = 256;
  localparam int unsigned FIFO_DEPTH_DEF = 2048;
  localparam int unsigned FIFO_LEN_W     = 11;
  localparam int unsigned SPACE_W        = 12;
  localparam int unsigned WCNT_W         = 9;
  localparam int unsigned DATA_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_START      = 3'd2,
    ST_WAIT_BUSY  = 3'd3,
    ST_READ       = 3'd4,
    ST_NEXT       = 3'd5
  } sd_img_state_e;

  // Swap the two bytes of a 16-bit SD word.
  function automatic logic [DATA_W-1:0] byte_swap16(input logic [DATA_W-1:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/sd_req_sync.sv
// Two-flop synchroniser plus rising-edge detect for an asynchronous request level.
module sd_req_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_async,
  output logic o_rise_c
);

  logic [2:0] r_ff;

  // Shift the request through two sync stages and one history stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff <= 3'b000;
    end else begin
      r_ff <= {r_ff[1:0], i_req_async};
    end
  end

  assign o_rise_c = r_ff[1] & ~r_ff[2];

endmodule

// File: rtl/sd_image_reader.sv
// Streams one stored image from the SD card, sector by sector, into the image FIFO.
// Optional build macro: SD_RD_BYTE_SWAP_EN swaps the two bytes of each word written to the FIFO.
module sd_image_reader
  import sd_img_pkg::*;
#(
  parameter logic [31:0] START_SEC    = 32'd16384,
  parameter logic [15:0] IMG_SECTORS  = 16'd1800,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned SEC_WORDS    = SEC_WORDS_DEF,
  parameter int unsigned BUSY_TIMEOUT = 4096
) (
  input  logic                  SD_clk_ref,
  input  logic                  sys_rst_n,
  input  logic                  sd_init_done,
  input  logic                  sys_image_read_req,
  input  logic                  rd_busy,
  input  logic                  rd_val_en,
  input  logic [DATA_W-1:0]     rd_val_data,
  output logic                  rd_start_en,
  output logic [31:0]           rd_sec_addr,
  input  logic [FIFO_LEN_W-1:0] fifo_len,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_W-1:0]     fifo_wr_data,
  output logic                  rd_image_done_n,
  output logic                  rd_err,
  output logic [15:0]           rd_sec_cnt
);

  localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT) + 1;

  sd_img_state_e       r_state;
  logic                r_pending;
  logic                r_start_en;
  logic [31:0]         r_sec_addr;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_done_n;
  logic                r_err;
  logic [15:0]         r_sec_cnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [TO_W-1:0]     r_to_cnt;

  logic                w_req_rise;
  logic [SPACE_W-1:0]  w_free;
  logic                w_space_ok;
  logic                w_wr_ok;
  logic [WCNT_W-1:0]   w_wcnt_nxt;
  logic [15:0]         w_cnt_nxt;
  logic [DATA_W-1:0]   w_data_in;

  sd_req_sync u_req_sync (
    .i_clk       (SD_clk_ref),
    .i_rst_n     (sys_rst_n),
    .i_req_async (sys_image_read_req),
    .o_rise_c    (w_req_rise)
  );

  // Free FIFO space must fit one whole sector before a read is issued.
  assign w_free     = SPACE_W'(FIFO_DEPTH) - SPACE_W'(fifo_len);
  assign w_space_ok = (w_free >= SPACE_W'(SEC_WORDS));
  assign w_wr_ok    = rd_val_en & ~fifo_full;
  assign w_wcnt_nxt = r_wcnt + WCNT_W'(w_wr_ok);
  assign w_cnt_nxt  = r_sec_cnt + 16'd1;

`ifdef SD_RD_BYTE_SWAP_EN
  assign w_data_in = byte_swap16(rd_val_data);
`else
  assign w_data_in = rd_val_data;
`endif

  // Sector read sequencer with registered command, FIFO and status outputs.
  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_start_en <= 1'b0;
      r_sec_addr <= START_SEC;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_done_n   <= 1'b1;
      r_err      <= 1'b0;
      r_sec_cnt  <= '0;
      r_wcnt     <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_start_en <= 1'b0;
      r_wr_en    <= 1'b0;
      r_done_n   <= 1'b1;
      if ((r_state != ST_IDLE) && !sd_init_done) begin
        r_err   <= 1'b1;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_req_rise) r_pending <= 1'b1;
            if (r_pending && sd_init_done) begin
              r_pending  <= 1'b0;
              r_sec_cnt  <= '0;
              r_sec_addr <= START_SEC;
              r_err      <= 1'b0;
              r_state    <= ST_WAIT_SPACE;
            end
          end
          ST_WAIT_SPACE: begin
            if (w_space_ok) begin
              r_start_en <= 1'b1;
              r_state    <= ST_START;
            end
          end
          ST_START: begin
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_BUSY;
          end
          ST_WAIT_BUSY: begin
            if (rd_busy) begin
              r_wcnt  <= '0;
              r_state <= ST_READ;
            end else if (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          ST_READ: begin
            if (rd_val_en) begin
              if (fifo_full) begin
                r_err <= 1'b1;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_data <= w_data_in;
              end
            end
            r_wcnt <= w_wcnt_nxt;
            if (!rd_busy) begin
              if (w_wcnt_nxt != WCNT_W'(SEC_WORDS)) r_err <= 1'b1;
              r_state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            r_sec_cnt  <= w_cnt_nxt;
            r_sec_addr <= r_sec_addr + 32'd1;
            if (w_cnt_nxt == IMG_SECTORS) begin
              r_done_n <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_state  <= ST_WAIT_SPACE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_start_en     = r_start_en;
  assign rd_sec_addr     = r_sec_addr;
  assign fifo_wr_en      = r_wr_en;
  assign fifo_wr_data    = r_wr_data;
  assign rd_image_done_n = r_done_n;
  assign rd_err          = r_err;
  assign rd_sec_cnt      = r_sec_cnt;

endmodule

// File: tb/tb_sd_image_reader.sv
// Scoreboard bench for sd_image_reader: an SD read-port model feeds sectors, a monitor checks FIFO writes.
module tb_sd_image_reader;

  logic        SD_clk_ref = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sd_init_done = 1'b1;
  logic        sys_image_read_req = 1'b0;
  logic        rd_busy = 1'b0;
  logic        rd_val_en = 1'b0;
  logic [15:0] rd_val_data = 16'h0000;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic [10:0] fifo_len = 11'd0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        rd_image_done_n;
  logic        rd_err;
  logic [15:0] rd_sec_cnt;

`ifdef SD_RD_BYTE_SWAP_EN
  localparam logic [15:0] EXP_1234 = 16'h3412;
`else
  localparam logic [15:0] EXP_1234 = 16'h1234;
`endif

  sd_image_reader #(
    .START_SEC    (32'd100),
    .IMG_SECTORS  (16'd3),
    .FIFO_DEPTH   (2048),
    .SEC_WORDS    (256),
    .BUSY_TIMEOUT (64)
  ) dut (
    .SD_clk_ref         (SD_clk_ref),
    .sys_rst_n          (sys_rst_n),
    .sd_init_done       (sd_init_done),
    .sys_image_read_req (sys_image_read_req),
    .rd_busy            (rd_busy),
    .rd_val_en          (rd_val_en),
    .rd_val_data        (rd_val_data),
    .rd_start_en        (rd_start_en),
    .rd_sec_addr        (rd_sec_addr),
    .fifo_len           (fifo_len),
    .fifo_full          (fifo_full),
    .fifo_wr_en         (fifo_wr_en),
    .fifo_wr_data       (fifo_wr_data),
    .rd_image_done_n    (rd_image_done_n),
    .rd_err             (rd_err),
    .rd_sec_cnt         (rd_sec_cnt)
  );

  always #5 SD_clk_ref = ~SD_clk_ref;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_start  = 0;
  int n_done   = 0;

  logic [15:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [15:0] m_data;
  logic [31:0] m_addr;

  bit model_en  = 1'b1;
  int model_sec = 0;
  int full_sec  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-defined word pattern: first word of each sector is 16'h1234, others {sector, word}.
  function automatic logic [15:0] pat(input int s, input int w);
    logic [7:0] sb;
    logic [7:0] wb;
    sb = 8'(s);
    wb = 8'(w);
    return (w == 0) ? 16'h1234 : {sb, wb};
  endfunction

  function automatic logic [15:0] exp_word(input int s, input int w);
    logic [15:0] d;
    d = pat(s, w);
    if (w == 0) return EXP_1234;
`ifdef SD_RD_BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  // SD controller read-port model: answers each rd_start_en with one sector of 256 words.
  initial begin
    forever begin
      @(negedge SD_clk_ref);
      if (rd_start_en && model_en && sys_rst_n) begin
        repeat (2) @(negedge SD_clk_ref);
        rd_busy = 1'b1;
        for (int w = 0; w < 256; w++) begin
          @(negedge SD_clk_ref);
          rd_val_en   = 1'b1;
          rd_val_data = pat(model_sec, w);
          fifo_full   = (model_sec == full_sec) && (w >= 10) && (w < 15);
          if (!fifo_full) exp_q.push_back(exp_word(model_sec, w));
          @(negedge SD_clk_ref);
          rd_val_en = 1'b0;
          fifo_full = 1'b0;
        end
        @(negedge SD_clk_ref);
        rd_busy = 1'b0;
        model_sec++;
      end
    end
  end

  // Monitor: pops expected words/addresses whenever the DUT presents a write or a sector start.
  always @(negedge SD_clk_ref) begin
    if (sys_rst_n) begin
      if (fifo_wr_en) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'(fifo_wr_data), 32'hFFFF_FFFF);
        end else begin
          m_data = exp_q.pop_front();
          chk("wr_data", 32'(fifo_wr_data), 32'(m_data));
        end
      end
      if (rd_start_en) begin
        n_start++;
        if (addr_q.size() == 0) begin
          chk("start_unexpected", rd_sec_addr, 32'hFFFF_FFFF);
        end else begin
          m_addr = addr_q.pop_front();
          chk("sec_addr", rd_sec_addr, m_addr);
        end
      end
      if (!rd_image_done_n) begin
        n_done++;
        chk("done_after_last_wr", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic wait_done(input int prev, input int budget);
    int k;
    k = 0;
    while (n_done == prev && k < budget) begin
      @(negedge SD_clk_ref);
      k++;
    end
    chk("done_seen", 32'(n_done), 32'(prev + 1));
  endtask

  int w0;
  int s0;
  int d0;
  int cyc;

  initial begin
    repeat (3) @(negedge SD_clk_ref);
    chk("rst_start_en", 32'(rd_start_en), 32'd0);
    chk("rst_sec_addr", rd_sec_addr, 32'd100);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_done_n", 32'(rd_image_done_n), 32'd1);
    chk("rst_err", 32'(rd_err), 32'd0);
    chk("rst_sec_cnt", 32'(rd_sec_cnt), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge SD_clk_ref);

    // Image 1: clean three-sector read, with an ignored request edge mid-image.
    model_sec = 0;
    full_sec  = -1;
    addr_q.push_back(32'd100);
    addr_q.push_back(32'd101);
    addr_q.push_back(32'd102);
    w0 = n_wr;
    d0 = n_done;
    sys_image_read_req = 1'b1;
    repeat (700) @(negedge SD_clk_ref);
    sys_image_read_req = 1'b0;
    repeat (4) @(negedge SD_clk_ref);
    sys_image_read_req = 1'b1;
    wait_done(d0, 4000);
    chk("img1_words", 32'(n_wr - w0), 32'd768);
    chk("img1_err", 32'(rd_err), 32'd0);
    chk("img1_sec_cnt", 32'(rd_sec_cnt), 32'd3);
    repeat (100) @(negedge SD_clk_ref);
    chk("img1_no_restart", 32'(n_start), 32'd3);
    chk("img1_single_done", 32'(n_done), 32'(d0 + 1));

    // Image 2: FIFO space throttle, then five dropped words in the middle sector.
    sys_image_read_req = 1'b0;
    repeat (5) @(negedge SD_clk_ref);
    fifo_len  = 11'd1900;
    model_sec = 0;
    full_sec  = 1;
    addr_q.push_back(32'd100);
    addr_q.push_back(32'd101);
    addr_q.push_back(32'd102);
    w0 = n_wr;
    d0 = n_done;
    s0 = n_start;
    sys_image_read_req = 1'b1;
    repeat (100) @(negedge SD_clk_ref);
    chk("throttle_no_start", 32'(n_start), 32'(s0));
    chk("restart_sec_cnt", 32'(rd_sec_cnt), 32'd0);
    fifo_len = 11'd1792;
    @(negedge SD_clk_ref);
    chk("throttle_release", 32'(rd_start_en), 32'd1);
    fifo_len = 11'd0;
    wait_done(d0, 4000);
    chk("img2_words", 32'(n_wr - w0), 32'd763);
    chk("img2_err", 32'(rd_err), 32'd1);
    chk("img2_sec_cnt", 32'(rd_sec_cnt), 32'd3);

    // Image 3: controller never goes busy, so the read times out without a done pulse.
    sys_image_read_req = 1'b0;
    model_en = 1'b0;
    repeat (5) @(negedge SD_clk_ref);
    addr_q.push_back(32'd100);
    d0 = n_done;
    s0 = n_start;
    sys_image_read_req = 1'b1;
    cyc = 0;
    while (!rd_start_en && cyc < 50) begin
      @(negedge SD_clk_ref);
      cyc++;
    end
    chk("to_start_seen", 32'(rd_start_en), 32'd1);
    chk("to_err_cleared", 32'(rd_err), 32'd0);
    cyc = 0;
    while (!rd_err && cyc < 200) begin
      @(negedge SD_clk_ref);
      cyc++;
    end
    // One START cycle, then BUSY_TIMEOUT cycles in WAIT_BUSY.
    chk("to_cycles", 32'(cyc), 32'd65);
    repeat (100) @(negedge SD_clk_ref);
    chk("to_no_done", 32'(n_done), 32'(d0));
    chk("to_no_retry", 32'(n_start), 32'(s0 + 1));
    chk("to_err_sticky", 32'(rd_err), 32'd1);
    chk("to_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
